// File: rtl/gba_line_cache.sv
// ----------------------------------------------------------------------------
// gba_line_cache
//
// Ring of NUM_LINES RGB888 line buffers sitting between the GBA capture stage
// and the HDMI image generator. The capture side fills one line at a time; the
// read side serves the clamped 3x3 neighbourhood around (actLine, curPxl) one
// cycle after the request, and tells the generator via sameLine whether it may
// move on to the next GBA line or must repeat the current one.
//
// Ports:
//   pxlClk       pixel clock, the only clock
//   rst          synchronous active-high reset
//   newFrameIn   one-cycle pulse at start of a GBA frame (clears line counters)
//   wrEn         write strobe for one capture pixel
//   wrPxl        capture pixel index (writes at or beyond LINE_WIDTH ignored)
//   wrRGB        capture pixel {r,g,b}
//   wrLineDone   pulse: current capture line complete
//   curPxl       read pixel index from the image generator
//   nextLine     pulse: reader advances one line (ignored while sameLine=1)
//   cacheUpdate  pulse: commit pending reader line to the active line
//   sameLine     1 = reader must not advance
//   nbhd         TL,TM,TR,CL,CM,CR,BL,BM,BR (TL in MSBs), each {r,g,b}
//   overflow     sticky: writer overran the reader window
//
// Optional feature: define LINE_CACHE_OVF_EN to drop writes that would clobber
// a line the reader still needs, and report it on the sticky overflow flag.
// Without it every write proceeds and overflow is tied to 0.
// ----------------------------------------------------------------------------
module gba_line_cache #(
    parameter int LINE_WIDTH  = 240,
    parameter int FRAME_LINES = 160,
    parameter int NUM_LINES   = 4,
    parameter int COLOR_W     = 8
) (
    input  logic                   pxlClk,
    input  logic                   rst,
    input  logic                   newFrameIn,
    input  logic                   wrEn,
    input  logic [7:0]             wrPxl,
    input  logic [3*COLOR_W-1:0]   wrRGB,
    input  logic                   wrLineDone,
    input  logic [7:0]             curPxl,
    input  logic                   nextLine,
    input  logic                   cacheUpdate,
    output logic                   sameLine,
    output logic [9*3*COLOR_W-1:0] nbhd,
    output logic                   overflow
);

    localparam int PIX_W = 3 * COLOR_W;
    localparam int LN_W  = $clog2(FRAME_LINES + 1);
    localparam int LIM_W = LN_W + 1;
    localparam int DEPTH = NUM_LINES * LINE_WIDTH;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [7:0]      LAST_PX = 8'(LINE_WIDTH - 1);
    localparam logic [LN_W-1:0] LAST_LN = LN_W'(FRAME_LINES - 1);
    localparam logic [LN_W-1:0] FULL_LN = LN_W'(FRAME_LINES);

    // Flat address of (line, pixel): line selects a ring slot.
    function automatic logic [AW-1:0] addr_of(input logic [LN_W-1:0] line,
                                              input logic [7:0]      pxl);
        int slot;
        slot = int'(line) % NUM_LINES;
        return AW'(slot * LINE_WIDTH + int'(pxl));
    endfunction

    logic [PIX_W-1:0]     r_mem [DEPTH];
    logic [LN_W-1:0]      r_wr_lines;
    logic [LN_W-1:0]      r_rd_line;
    logic [LN_W-1:0]      r_act_line;
    logic                 r_same_line;
    logic [9*PIX_W-1:0]   r_nbhd;

    logic [LN_W-1:0]      w_wr_nxt;
    logic [LN_W-1:0]      w_rd_nxt;
    logic [LN_W-1:0]      w_act_nxt;
    logic [LIM_W-1:0]     w_rd_lim;
    logic                 w_same_nxt;
    logic                 w_ovf_hit;
    logic                 w_wr_ok;
    logic [AW-1:0]        w_wr_addr;
    logic [LN_W-1:0]      w_lines [3];
    logic [7:0]           w_pxls  [3];
    logic [7:0]           w_c;
    logic [9*PIX_W-1:0]   w_nbhd_nxt;

    // ---------------- line counters and advance control ----------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_wr_nxt  = r_wr_lines;
        w_rd_nxt  = r_rd_line;
        w_act_nxt = r_act_line;
        if (newFrameIn) begin
            w_wr_nxt  = '0;
            w_rd_nxt  = '0;
            w_act_nxt = '0;
        end else begin
            if (wrLineDone && r_wr_lines != FULL_LN)
                w_wr_nxt = r_wr_lines + 1'b1;
            if (nextLine && !r_same_line)
                w_rd_nxt = r_rd_line + 1'b1;
            // A commit in the same cycle as an advance takes the new line.
            if (cacheUpdate)
                w_act_nxt = w_rd_nxt;
        end

        // sameLine is computed from next-state counters so it is valid the
        // cycle the counters change; a stale 0 would let the reader overrun.
        w_rd_lim = LIM_W'(w_rd_nxt) + LIM_W'(3);
        if (w_rd_lim > LIM_W'(FRAME_LINES))
            w_rd_lim = LIM_W'(FRAME_LINES);
        w_same_nxt = !(LIM_W'(w_wr_nxt) >= w_rd_lim) || (w_rd_nxt == LAST_LN);
    end

    // ---------------- write side ----------------
`ifdef LINE_CACHE_OVF_EN
    logic r_overflow;

    // Writer already holds line actLine+3, which shares a slot with actLine-1.
    assign w_ovf_hit = wrEn && !newFrameIn && (r_wr_lines < FULL_LN) &&
                       (LIM_W'(r_wr_lines) > LIM_W'(r_act_line) + LIM_W'(2));

    always_ff @(posedge pxlClk) begin
        if (rst || newFrameIn)
            r_overflow <= 1'b0;
        else if (w_ovf_hit)
            r_overflow <= 1'b1;
    end

    assign overflow = r_overflow;
`else
    assign w_ovf_hit = 1'b0;
    assign overflow  = 1'b0;
`endif

    assign w_wr_ok   = wrEn && (wrPxl <= LAST_PX) && !w_ovf_hit;
    // A write alongside newFrameIn belongs to line 0 of the new frame.
    assign w_wr_addr = addr_of(newFrameIn ? '0 : r_wr_lines, wrPxl);

    // NOTE: buffer storage has no reset; its contents are don't-care until written.
    always_ff @(posedge pxlClk) begin
        if (w_wr_ok)
            r_mem[w_wr_addr] <= wrRGB;
    end

    // ---------------- read side ----------------
    always_comb begin
        w_c = (curPxl > LAST_PX) ? LAST_PX : curPxl;
        w_pxls[0] = (w_c == 8'd0) ? 8'd0 : w_c - 8'd1;
        w_pxls[1] = w_c;
        w_pxls[2] = (w_c == LAST_PX) ? LAST_PX : w_c + 8'd1;

        w_lines[0] = (r_act_line == '0) ? '0 : r_act_line - 1'b1;
        w_lines[1] = r_act_line;
        w_lines[2] = (r_act_line >= LAST_LN) ? LAST_LN : r_act_line + 1'b1;

        // Reading here, before the write commits at the edge, yields old data
        // on a same-address collision.
        w_nbhd_nxt = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w_nbhd_nxt[(8 - (r * 3 + c)) * PIX_W +: PIX_W] =
                    r_mem[addr_of(w_lines[r], w_pxls[c])];
    end

    // ---------------- state registers ----------------
    always_ff @(posedge pxlClk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            r_wr_lines  <= '0;
            r_rd_line   <= '0;
            r_act_line  <= '0;
            r_same_line <= 1'b1;
            r_nbhd      <= '0;
        end else begin
            r_wr_lines  <= w_wr_nxt;
            r_rd_line   <= w_rd_nxt;
            r_act_line  <= w_act_nxt;
            r_same_line <= w_same_nxt;
            r_nbhd      <= w_nbhd_nxt;
        end
    end

    assign sameLine = r_same_line;
    assign nbhd     = r_nbhd;

endmodule

// File: tb/tb_gba_line_cache.sv
// ----------------------------------------------------------------------------
// tb_gba_line_cache
//
// Directed bench for gba_line_cache with default parameters. Capture pixels
// carry {line, pixel, 8'h00} so every neighbourhood entry is predictable.
// Inputs change 1 time unit after the rising edge and outputs are checked
// there too, i.e. well away from the next sampling edge.
// ----------------------------------------------------------------------------
module tb_gba_line_cache;

    localparam int TL = 0, TM = 1, TR = 2, CL = 3, CM = 4, CR = 5, BL = 6, BM = 7, BR = 8;

    logic         pxlClk = 1'b0;
    logic         rst = 1'b1;
    logic         newFrameIn = 1'b0;
    logic         wrEn = 1'b0;
    logic [7:0]   wrPxl = '0;
    logic [23:0]  wrRGB = '0;
    logic         wrLineDone = 1'b0;
    logic [7:0]   curPxl = '0;
    logic         nextLine = 1'b0;
    logic         cacheUpdate = 1'b0;
    logic         sameLine;
    logic [215:0] nbhd;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    gba_line_cache dut (
        .pxlClk      (pxlClk),
        .rst         (rst),
        .newFrameIn  (newFrameIn),
        .wrEn        (wrEn),
        .wrPxl       (wrPxl),
        .wrRGB       (wrRGB),
        .wrLineDone  (wrLineDone),
        .curPxl      (curPxl),
        .nextLine    (nextLine),
        .cacheUpdate (cacheUpdate),
        .sameLine    (sameLine),
        .nbhd        (nbhd),
        .overflow    (overflow)
    );

    always #5 pxlClk = ~pxlClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] px(input int line, input int p);
        logic [7:0] l8, p8;
        l8 = 8'(line);
        p8 = 8'(p);
        return {l8, p8, 8'h00};
    endfunction

    function automatic logic [23:0] ent(input int idx);
        return nbhd[(8 - idx) * 24 +: 24];
    endfunction

    task automatic cyc();
        @(posedge pxlClk);
        #1;
    endtask

    task automatic write_line(input int line);
        for (int p = 0; p < 240; p++) begin
            wrEn  = 1'b1;
            wrPxl = 8'(p);
            wrRGB = px(line, p);
            cyc();
        end
        wrEn       = 1'b0;
        wrLineDone = 1'b1;
        cyc();
        wrLineDone = 1'b0;
    endtask

    task automatic advance_commit();
        nextLine    = 1'b1;
        cacheUpdate = 1'b1;
        cyc();
        nextLine    = 1'b0;
        cacheUpdate = 1'b0;
    endtask

    initial begin
        // ---- reset ----
        repeat (3) cyc();
        check("reset_sameLine", 32'(sameLine), 32'd1);
        check("reset_nbhd_zero", 32'(nbhd == '0), 32'd1);
        check("reset_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        cyc();

        // ---- fill lines 0..2, watch sameLine release ----
        curPxl = 8'd5;
        write_line(0);
        check("same_after_line0", 32'(sameLine), 32'd1);
        write_line(1);
        check("same_after_line1", 32'(sameLine), 32'd1);
        write_line(2);
        check("same_after_line2", 32'(sameLine), 32'd0);
        cyc();
        check("l0_CM", 32'(ent(CM)), 32'(px(0, 5)));
        check("l0_TM_clamped", 32'(ent(TM)), 32'(px(0, 5)));
        check("l0_BM", 32'(ent(BM)), 32'(px(1, 5)));
        check("l0_TL", 32'(ent(TL)), 32'(px(0, 4)));
        check("l0_BR", 32'(ent(BR)), 32'(px(1, 6)));

        // ---- horizontal clamps ----
        curPxl = 8'd0;
        cyc();
        check("px0_CL", 32'(ent(CL)), 32'(px(0, 0)));
        check("px0_CM", 32'(ent(CM)), 32'(px(0, 0)));
        check("px0_CR", 32'(ent(CR)), 32'(px(0, 1)));
        curPxl = 8'd239;
        cyc();
        check("px239_CR", 32'(ent(CR)), 32'(px(0, 239)));
        check("px239_CM", 32'(ent(CM)), 32'(px(0, 239)));
        curPxl = 8'd250;
        cyc();
        check("px250_CM", 32'(ent(CM)), 32'(px(0, 239)));
        check("px250_CL", 32'(ent(CL)), 32'(px(0, 238)));
        check("px250_BR", 32'(ent(BR)), 32'(px(1, 239)));

        // ---- writer stalled at 3 lines ----
        curPxl   = 8'd5;
        nextLine = 1'b1;
        cyc();
        nextLine = 1'b0;
        check("stall_same_set", 32'(sameLine), 32'd1);
        nextLine = 1'b1;
        cyc();
        nextLine = 1'b0;
        cacheUpdate = 1'b1;
        cyc();
        cacheUpdate = 1'b0;
        cyc();
        check("stall_act1_CM", 32'(ent(CM)), 32'(px(1, 5)));
        check("stall_act1_TM", 32'(ent(TM)), 32'(px(0, 5)));
        check("stall_act1_BM", 32'(ent(BM)), 32'(px(2, 5)));
        check("stall_same_held", 32'(sameLine), 32'd1);

        // ---- rest of the frame, reader two lines behind writer ----
        for (int l = 3; l < 160; l++) begin
            write_line(l);
            if (l == 6) begin
                // reader sits at line 4; advance and commit together
                advance_commit();
                check("adv4_act_old_CM", 32'(ent(CM)), 32'(px(4, 5)));
                cyc();
                check("adv4_act5_CM", 32'(ent(CM)), 32'(px(5, 5)));
                check("adv4_act5_BM", 32'(ent(BM)), 32'(px(6, 5)));
            end else begin
                advance_commit();
            end
        end
        check("l158_same", 32'(sameLine), 32'd0);
        advance_commit();
        check("l159_same_forced", 32'(sameLine), 32'd1);
        cyc();
        check("l159_CM", 32'(ent(CM)), 32'(px(159, 5)));
        check("l159_BM_eq_CM", 32'(ent(BM)), 32'(px(159, 5)));
        check("l159_TM", 32'(ent(TM)), 32'(px(158, 5)));
        advance_commit();
        cyc();
        check("l159_hold_CM", 32'(ent(CM)), 32'(px(159, 5)));

        // ---- new frame with a write in the same cycle ----
        curPxl     = 8'd7;
        newFrameIn = 1'b1;
        wrEn       = 1'b1;
        wrPxl      = 8'd7;
        wrRGB      = 24'hABCDEF;
        cyc();
        newFrameIn = 1'b0;
        wrEn       = 1'b0;
        check("nf_same", 32'(sameLine), 32'd1);
        cyc();
        check("nf_CM_buf0", 32'(ent(CM)), 32'h00ABCDEF);
        check("nf_BM_line1", 32'(ent(BM)), 32'(px(157, 7)));

        // ---- out-of-range write is ignored ----
        wrEn  = 1'b1;
        wrPxl = 8'd240;
        wrRGB = 24'h123456;
        cyc();
        wrEn   = 1'b0;
        curPxl = 8'd0;
        cyc();
        check("badpx_BM", 32'(ent(BM)), 32'(px(157, 0)));
        check("badpx_CM", 32'(ent(CM)), 32'(px(156, 0)));

        // ---- writer runs ahead of an idle reader ----
        write_line(0);
        write_line(1);
        write_line(2);
        check("ovf_before", 32'(overflow), 32'd0);
        wrEn  = 1'b1;
        wrPxl = 8'd7;
        wrRGB = 24'h777777;
        cyc();
        wrEn = 1'b0;
`ifdef LINE_CACHE_OVF_EN
        check("ovf_set", 32'(overflow), 32'd1);
        repeat (4) cyc();
        check("ovf_held", 32'(overflow), 32'd1);
        newFrameIn = 1'b1;
        cyc();
        newFrameIn = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
`else
        check("ovf_tied_low", 32'(overflow), 32'd0);
        repeat (4) cyc();
        check("ovf_still_low", 32'(overflow), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gba_line_cache.md
Name: gba_line_cache

Overview:
- Line cache directly upstream of the HDMI image generator.
- Stores GBA RGB888 lines written by the capture stage.
- Serves the 3x3 pixel neighbourhood around (current line, curPxl) to the image generator for pass-through, grid and smoothing.
- Tells the image generator, via sameLine, whether it may advance to the next GBA line or must repeat the current one.

Parameters:
LINE_WIDTH, 240, pixels per GBA line
FRAME_LINES, 160, lines per GBA frame
NUM_LINES, 4, line buffers in the ring (minimum 4)
COLOR_W, 8, bits per colour channel

Ports:
pxlClk  in  1  pixel clock; the only clock
rst  in  1  synchronous active-high reset
newFrameIn  in  1  one-cycle pulse at start of GBA frame
wrEn  in  1  write strobe for one capture pixel
wrPxl  in  8  capture pixel index, 0..LINE_WIDTH-1
wrRGB  in  3*COLOR_W  capture pixel {r,g,b}
wrLineDone  in  1  pulse: current capture line complete
curPxl  in  8  read pixel index, from the image generator
nextLine  in  1  pulse: reader advances one line
cacheUpdate  in  1  pulse: commit the pending line selection (end of visible span)
sameLine  out  1  1 = reader must not advance
nbhd  out  9*3*COLOR_W  neighbourhood, TL,TM,TR,CL,CM,CR,BL,BM,BR; TL in MSBs; each entry {r,g,b}
overflow  out  1  sticky: writer overran the reader window

Behaviour:
- Reset: all counters 0, sameLine=1, nbhd=0, overflow=0. Buffer contents are undefined.
- Write side:
  - wrLines counts completed lines this frame, 0..FRAME_LINES.
  - A wrEn stores wrRGB at buffer (wrLines mod NUM_LINES), address wrPxl.
  - A wrEn with wrPxl >= LINE_WIDTH is ignored.
  - wrLineDone increments wrLines, saturating at FRAME_LINES.
- Read side:
  - rdLine is the pending reader line, 0..FRAME_LINES-1.
  - actLine is the committed copy of rdLine used for all reads.
  - nextLine with sameLine=0 increments rdLine. nextLine with sameLine=1 is ignored.
  - cacheUpdate copies rdLine to actLine. If cacheUpdate and nextLine occur together, actLine takes the incremented value.
- sameLine is registered. It equals NOT (wrLines >= min(rdLine+3, FRAME_LINES)), and is forced to 1 when rdLine = FRAME_LINES-1.
- Vertical clamp: prev line = max(actLine-1, 0); next line = min(actLine+1, FRAME_LINES-1).
- Horizontal clamp:
  - c = min(curPxl, LINE_WIDTH-1).
  - prev pixel = max(c-1, 0); next pixel = min(c+1, LINE_WIDTH-1).
- Latency: nbhd is registered, exactly 1 cycle after curPxl/actLine.
- Read and write to the same buffer address in the same cycle returns the old data.
- newFrameIn clears wrLines, rdLine and actLine to 0 in the next cycle.
  - Takes priority over a simultaneous wrLineDone/nextLine.
  - A wrEn in the same cycle writes buffer 0.
- Reset mid-frame behaves as newFrameIn, plus sameLine=1 and nbhd=0.

Optional Feature:
- Macro: LINE_CACHE_OVF_EN.
- Defined:
  - A wrEn while wrLines > actLine+2, with wrLines < FRAME_LINES, is dropped.
  - The same condition sets overflow. overflow is cleared only by rst or newFrameIn.
- Undefined: no window check; all writes proceed; overflow tied to 0.

Test Plan:
- Reset, then write lines 0..2 with pixel value = {line, pxl, 8'h00}. sameLine goes 1 -> 0 the cycle after the third wrLineDone. With curPxl=5 at line 0, nbhd CM = {0,5,0}, TM = {0,5,0} (clamped), BM = {1,5,0}.
- Edge clamp: curPxl=0 -> CL = CM = {0,0,0}. curPxl=239 -> CR = CM = {0,239,0}. curPxl=250 -> CM = {0,239,0}.
- Writer stalled at wrLines=3 with rdLine=0: nextLine advances to 1; sameLine then 1; a further nextLine is ignored and actLine stays 1 after cacheUpdate.
- Full frame of 160 lines: at rdLine=159, BM = CM and sameLine=1. newFrameIn resets rdLine/actLine to 0 and sameLine to 1.
- Simultaneous nextLine and cacheUpdate at rdLine=4: actLine=5 the next cycle; nbhd reflects line 5 two cycles after.
- With LINE_CACHE_OVF_EN, actLine=0, wrLines=3: a wrEn is dropped, overflow=1 and held until newFrameIn.
